// File: rtl/rob_param_if.sv
// rob_param_if: bundle of the reorder buffer's issue, status, query,
// write-back, commit and flush signals.
//   master : issue-stage / write-back / store-unit side (drives requests)
//   slave  : the reorder buffer (drives status, queries, commit, flush)
// Parameters: IDX_W (entry index width), NUM_WB (write-back channels).
interface rob_param_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned NUM_WB = 2
);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  // issue
  logic                     iss_valid;
  logic                     iss_ready;
  logic [1:0]               iss_type;
  logic [DATA_W-1:0]        iss_value;
  logic [RD_W-1:0]          iss_rd;
  logic [DATA_W-1:0]        iss_pred_pc;
  // occupancy
  logic                     full;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic [IDX_W-1:0]         tail_idx;
  // queries
  logic [IDX_W-1:0]         q1_idx;
  logic [IDX_W-1:0]         q2_idx;
  logic                     q1_ready;
  logic                     q2_ready;
  logic [DATA_W-1:0]        q1_value;
  logic [DATA_W-1:0]        q2_value;
  // write-back
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_idx;
  logic [NUM_WB*DATA_W-1:0] wb_value;
  // head / commit
  logic [IDX_W-1:0]         head_idx;
  logic                     head_valid;
  logic                     st_ok;
  logic                     commit_valid;
  logic [RD_W-1:0]          commit_rd;
  logic [DATA_W-1:0]        commit_value;
  logic [IDX_W-1:0]         commit_idx;
  // mispredict flush
  logic                     flush_out;
  logic [DATA_W-1:0]        flush_pc;

  modport master (
    output iss_valid, iss_ready, iss_type, iss_value, iss_rd, iss_pred_pc,
    output q1_idx, q2_idx, wb_valid, wb_idx, wb_value, st_ok,
    input  full, empty, count, tail_idx, q1_ready, q2_ready, q1_value, q2_value,
    input  head_idx, head_valid, commit_valid, commit_rd, commit_value, commit_idx,
    input  flush_out, flush_pc
  );

  modport slave (
    input  iss_valid, iss_ready, iss_type, iss_value, iss_rd, iss_pred_pc,
    input  q1_idx, q2_idx, wb_valid, wb_idx, wb_value, st_ok,
    output full, empty, count, tail_idx, q1_ready, q2_ready, q1_value, q2_value,
    output head_idx, head_valid, commit_valid, commit_rd, commit_value, commit_idx,
    output flush_out, flush_pc
  );
endinterface

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer. One issue per cycle into the tail,
// NUM_WB write-back channels mark entries ready, one in-order commit per
// cycle from the head. Branch entries compare their written-back next PC
// against the predicted PC at commit; a mismatch empties the buffer and
// raises a one-cycle flush_out with the corrected flush_pc.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-low reset
//   rdy_in  : stall, low freezes all state and suppresses commit
//   bus     : rob_param_if.slave (issue, status, query, write-back,
//             commit, flush)
// Optional feature macro: ROB_WB_BYPASS_EN -- when defined, the query
// ports also see same-cycle write-backs; undefined, queries show
// registered entry state only.
module rob_param #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned NUM_WB = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  rob_param_if.slave   bus
);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;
  // entry types (0 = register write, not referenced explicitly)
  localparam logic [1:0]  TYPE_ST = 2'd1;
  localparam logic [1:0]  TYPE_BR = 2'd2;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [1:0]        type_q    [DEPTH];
  logic [1:0]        type_d    [DEPTH];
  logic [DATA_W-1:0] value_q   [DEPTH];
  logic [DATA_W-1:0] value_d   [DEPTH];
  logic [RD_W-1:0]   rd_q      [DEPTH];
  logic [RD_W-1:0]   rd_d      [DEPTH];
  logic [DATA_W-1:0] pred_pc_q [DEPTH];
  logic [DATA_W-1:0] pred_pc_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

  logic              full_c;
  logic              empty_c;
  logic              issue_c;
  logic              commit_c;
  logic              mispredict_c;
  logic              head_rd_zero_c;
  logic              q1_ready_c, q2_ready_c;
  logic [DATA_W-1:0] q1_value_c, q2_value_c;

  // Occupancy flags come from the registered count only, so a commit in
  // the same cycle never frees a slot for a simultaneous issue.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  assign issue_c  = bus.iss_valid && !full_c && !flush_q && rdy_in;
  assign commit_c = rdy_in && !flush_q && busy_q[head_q] && ready_q[head_q] &&
                    ((type_q[head_q] != TYPE_ST) || bus.st_ok);
  assign mispredict_c = commit_c && (type_q[head_q] == TYPE_BR) &&
                        (value_q[head_q] != pred_pc_q[head_q]);
  assign head_rd_zero_c = (type_q[head_q] == TYPE_ST) || (type_q[head_q] == TYPE_BR);

  // Next-state: write-back, commit, issue, count and flush bookkeeping.
  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    type_d     = type_q;
    value_d    = value_q;
    rd_d       = rd_q;
    pred_pc_d  = pred_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;

    if (rdy_in) begin
      if (flush_q) begin
        // flush cycle: issue and write-back are dropped
        flush_d = 1'b0;
      end else if (mispredict_c) begin
        busy_d     = '0;
        ready_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        flush_d    = 1'b1;
        flush_pc_d = value_q[head_q];
      end else begin
        // later channels overwrite earlier ones on an index collision
        for (int unsigned k = 0; k < NUM_WB; k++) begin
          if (bus.wb_valid[k] && busy_q[bus.wb_idx[k*IDX_W +: IDX_W]]) begin
            ready_d[bus.wb_idx[k*IDX_W +: IDX_W]] = 1'b1;
            value_d[bus.wb_idx[k*IDX_W +: IDX_W]] = bus.wb_value[k*DATA_W +: DATA_W];
          end
        end
        if (commit_c) begin
          busy_d[head_q] = 1'b0;
          head_d         = head_q + IDX_W'(1);
        end
        if (issue_c) begin
          busy_d[tail_q]    = 1'b1;
          ready_d[tail_q]   = bus.iss_ready;
          type_d[tail_q]    = bus.iss_type;
          value_d[tail_q]   = bus.iss_value;
          rd_d[tail_q]      = bus.iss_rd;
          pred_pc_d[tail_q] = bus.iss_pred_pc;
          tail_d            = tail_q + IDX_W'(1);
        end
        case ({issue_c, commit_c})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        type_q[i]    <= '0;
        value_q[i]   <= '0;
        rd_q[i]      <= '0;
        pred_pc_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      type_q     <= type_d;
      value_q    <= value_d;
      rd_q       <= rd_d;
      pred_pc_q  <= pred_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Query ports; registered ready state takes priority over any bypass.
  always_comb begin
    q1_ready_c = ready_q[bus.q1_idx];
    q1_value_c = value_q[bus.q1_idx];
    q2_ready_c = ready_q[bus.q2_idx];
    q2_value_c = value_q[bus.q2_idx];
`ifdef ROB_WB_BYPASS_EN
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (!ready_q[bus.q1_idx] && bus.wb_valid[k] &&
          (bus.wb_idx[k*IDX_W +: IDX_W] == bus.q1_idx)) begin
        q1_ready_c = 1'b1;
        q1_value_c = bus.wb_value[k*DATA_W +: DATA_W];
      end
      if (!ready_q[bus.q2_idx] && bus.wb_valid[k] &&
          (bus.wb_idx[k*IDX_W +: IDX_W] == bus.q2_idx)) begin
        q2_ready_c = 1'b1;
        q2_value_c = bus.wb_value[k*DATA_W +: DATA_W];
      end
    end
`endif
  end

  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.count        = count_q;
  assign bus.tail_idx     = tail_q;
  assign bus.head_idx     = head_q;
  assign bus.head_valid   = busy_q[head_q];
  assign bus.q1_ready     = q1_ready_c;
  assign bus.q1_value     = q1_value_c;
  assign bus.q2_ready     = q2_ready_c;
  assign bus.q2_value     = q2_value_c;
  assign bus.commit_valid = commit_c;
  assign bus.commit_rd    = (commit_c && !head_rd_zero_c) ? rd_q[head_q] : '0;
  assign bus.commit_value = commit_c ? value_q[head_q] : '0;
  assign bus.commit_idx   = commit_c ? head_q : '0;
  assign bus.flush_out    = flush_q;
  assign bus.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed scenarios plus randomized traffic for rob_param,
// checked every cycle against an entry-array model whose tail is derived
// from head + occupancy.
module tb_rob_param;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int NUM_WB = 2;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  rob_param_if #(.IDX_W(IDX_W), .NUM_WB(NUM_WB)) bus ();

  rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit        busy;
    bit        ready;
    bit [1:0]  typ;
    bit [31:0] value;
    bit [4:0]  rd;
    bit [31:0] pred;
  } ent_t;

  ent_t      m [DEPTH];
  int        m_head, m_count;
  bit        m_flush;
  bit [31:0] m_flush_pc;
  int        total = 0;
  int        bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_tail();
    return (m_head + m_count) % DEPTH;
  endfunction

  function automatic bit m_commit();
    ent_t e;
    e = m[m_head];
    return (rdy_in === 1'b1) && !m_flush && e.busy && e.ready &&
           (e.typ != 2'd1 || bus.st_ok === 1'b1);
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = '{busy: 0, ready: 0, typ: 0, value: 0, rd: 0, pred: 0};
    m_head = 0; m_count = 0; m_flush = 0; m_flush_pc = 0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_step();
    bit cm, acc;
    int t;
    if (rdy_in !== 1'b1) return;
    if (m_flush) begin m_flush = 0; return; end
    cm = m_commit();
    t  = m_tail();
    if (cm && m[m_head].typ == 2'd2 && m[m_head].value != m[m_head].pred) begin
      foreach (m[i]) begin m[i].busy = 0; m[i].ready = 0; end
      m_flush_pc = m[m_head].value;
      m_head = 0; m_count = 0; m_flush = 1;
      return;
    end
    acc = (bus.iss_valid === 1'b1) && (m_count < DEPTH);
    for (int k = 0; k < NUM_WB; k++) begin
      if (bus.wb_valid[k]) begin
        int w;
        w = int'(bus.wb_idx[k*IDX_W +: IDX_W]);
        if (m[w].busy) begin
          m[w].ready = 1;
          m[w].value = bus.wb_value[k*32 +: 32];
        end
      end
    end
    if (cm) begin
      m[m_head].busy = 0;
      m_head = (m_head + 1) % DEPTH;
      m_count--;
    end
    if (acc) begin
      m[t] = '{busy: 1, ready: bus.iss_ready, typ: bus.iss_type, value: bus.iss_value,
               rd: bus.iss_rd, pred: bus.iss_pred_pc};
      m_count++;
    end
  endtask

  task automatic q_exp(input int idx, output bit r, output bit [31:0] v);
    r = m[idx].ready;
    v = m[idx].value;
`ifdef ROB_WB_BYPASS_EN
    if (!r) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (bus.wb_valid[k] && int'(bus.wb_idx[k*IDX_W +: IDX_W]) == idx) begin
          r = 1;
          v = bus.wb_value[k*32 +: 32];
        end
      end
    end
`endif
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin : cmp
    ent_t      e;
    bit        cm, er;
    bit [31:0] ev;
    e  = m[m_head];
    cm = m_commit();
    chk("full",         32'(bus.full),         32'(m_count == DEPTH));
    chk("empty",        32'(bus.empty),        32'(m_count == 0));
    chk("count",        32'(bus.count),        32'(m_count));
    chk("tail_idx",     32'(bus.tail_idx),     32'(m_tail()));
    chk("head_idx",     32'(bus.head_idx),     32'(m_head));
    chk("head_valid",   32'(bus.head_valid),   32'(e.busy));
    chk("commit_valid", 32'(bus.commit_valid), 32'(cm));
    chk("commit_rd",    32'(bus.commit_rd),    (cm && e.typ == 2'd0) ? 32'(e.rd) : 32'd0);
    chk("commit_value", bus.commit_value,      cm ? e.value : 32'd0);
    chk("commit_idx",   32'(bus.commit_idx),   cm ? 32'(m_head) : 32'd0);
    chk("flush_out",    32'(bus.flush_out),    32'(m_flush));
    chk("flush_pc",     bus.flush_pc,          m_flush_pc);
    q_exp(int'(bus.q1_idx), er, ev);
    chk("q1_ready", 32'(bus.q1_ready), 32'(er));
    chk("q1_value", bus.q1_value, ev);
    q_exp(int'(bus.q2_idx), er, ev);
    chk("q2_ready", 32'(bus.q2_ready), 32'(er));
    chk("q2_value", bus.q2_value, ev);
  end

  task automatic tick();
    @(posedge clk_in);
    if (rst_in === 1'b1) model_step();
    #1;
  endtask

  task automatic quiet();
    bus.iss_valid = 0; bus.iss_ready = 0; bus.iss_type = 0; bus.iss_value = 0;
    bus.iss_rd = 0; bus.iss_pred_pc = 0; bus.wb_valid = 0; bus.wb_idx = 0;
    bus.wb_value = 0; bus.st_ok = 0;
  endtask

  task automatic issue(input bit [1:0] t, input bit rdy, input bit [31:0] v,
                       input bit [4:0] rd, input bit [31:0] pc);
    bus.iss_valid = 1; bus.iss_type = t; bus.iss_ready = rdy;
    bus.iss_value = v; bus.iss_rd = rd; bus.iss_pred_pc = pc;
  endtask

  task automatic wb(input int k, input int idx, input bit [31:0] v);
    bus.wb_valid[k] = 1'b1;
    bus.wb_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
    bus.wb_value[k*32 +: 32] = v;
  endtask

  initial begin
    int bi;
    rst_in = 0; rdy_in = 1;
    quiet();
    bus.q1_idx = 0; bus.q2_idx = 0;
    model_reset();
    tick(); tick();
    rst_in = 1;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_tail",  32'(bus.tail_idx), 32'd0);

    // fill to full, then a dropped 17th issue
    for (int i = 0; i < DEPTH; i++) begin
      issue(2'd0, 1'b0, 32'(i), 5'(i + 1), 32'd0);
      tick();
    end
    chk("fill_full",  32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    tick();
    quiet();
    chk("drop_tail",  32'(bus.tail_idx), 32'd0);
    chk("drop_count", 32'(bus.count), 32'd16);
    wb(0, 0, 32'h55);
    tick();
    quiet();
    #1;
    chk("full_commit_valid", 32'(bus.commit_valid), 32'd1);
    chk("full_commit_value", bus.commit_value, 32'h55);
    chk("full_commit_rd",    32'(bus.commit_rd), 32'd1);
    tick();

    // drain entries 1..14, refill to count 5 with head at 15
    for (int i = 1; i <= 14; i++) begin
      wb(0, i, 32'h100 + 32'(i));
      tick();
    end
    quiet();
    tick();
    chk("drain_head",  32'(bus.head_idx), 32'd15);
    chk("drain_count", 32'(bus.count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      issue(2'd0, 1'b0, 32'h0, 5'd3, 32'd0);
      tick();
    end
    quiet();
    chk("five_count", 32'(bus.count), 32'd5);
    chk("five_tail",  32'(bus.tail_idx), 32'd4);
    wb(1, 15, 32'hABC);
    tick();
    quiet();
    issue(2'd0, 1'b0, 32'h0, 5'd4, 32'd0);
    #1;
    chk("simul_commit", 32'(bus.commit_valid), 32'd1);
    tick();
    quiet();
    chk("simul_count", 32'(bus.count), 32'd5);
    chk("simul_head",  32'(bus.head_idx), 32'd0);
    chk("simul_tail",  32'(bus.tail_idx), 32'd5);

    // empty the buffer
    wb(0, 0, 32'h1); wb(1, 1, 32'h2); tick();
    quiet(); wb(0, 2, 32'h3); wb(1, 3, 32'h4); tick();
    quiet(); wb(0, 4, 32'h5); tick();
    quiet();
    repeat (4) tick();
    chk("clear_empty", 32'(bus.empty), 32'd1);

    // store gating
    issue(2'd1, 1'b1, 32'h77, 5'd9, 32'd0);
    tick();
    quiet();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("st_hold_commit", 32'(bus.commit_valid), 32'd0);
      chk("st_hold_head",   32'(bus.head_valid), 32'd1);
      tick();
    end
    bus.st_ok = 1;
    #1;
    chk("st_commit_valid", 32'(bus.commit_valid), 32'd1);
    chk("st_commit_rd",    32'(bus.commit_rd), 32'd0);
    chk("st_commit_value", bus.commit_value, 32'h77);
    tick();
    quiet();

    // branch mispredict
    bi = m_tail();
    issue(2'd2, 1'b0, 32'h0, 5'd7, 32'h104);
    tick();
    quiet();
    wb(0, bi, 32'h200);
    tick();
    quiet();
    issue(2'd0, 1'b0, 32'h9, 5'd2, 32'd0);
    #1;
    chk("br_commit_valid", 32'(bus.commit_valid), 32'd1);
    chk("br_commit_rd",    32'(bus.commit_rd), 32'd0);
    tick();
    chk("flush_out", 32'(bus.flush_out), 32'd1);
    chk("flush_pc",  bus.flush_pc, 32'h200);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_tail",  32'(bus.tail_idx), 32'd0);
    tick();
    chk("post_flush_out",   32'(bus.flush_out), 32'd0);
    chk("post_flush_count", 32'(bus.count), 32'd0);
    tick();
    chk("first_issue_count", 32'(bus.count), 32'd1);
    repeat (3) tick();
    quiet();

    // write-back collision on idx 3
    wb(0, 3, 32'h11); wb(1, 3, 32'h22);
    bus.q1_idx = 4'd3;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("coll_bypass_ready", 32'(bus.q1_ready), 32'd1);
    chk("coll_bypass_value", bus.q1_value, 32'h22);
`else
    chk("coll_early_ready", 32'(bus.q1_ready), 32'd0);
`endif
    tick();
    quiet();
    #1;
    chk("coll_ready", 32'(bus.q1_ready), 32'd1);
    chk("coll_value", bus.q1_value, 32'h22);
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      quiet();
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 9);
        issue(r < 6 ? 2'd0 : (r < 8 ? 2'd1 : 2'd2), 1'($urandom_range(0, 1)),
              $urandom, 5'($urandom), $urandom);
        if (bus.iss_type == 2'd2 && $urandom_range(0, 1) == 1) bus.iss_value = bus.iss_pred_pc;
      end
      for (int k = 0; k < NUM_WB; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          int w;
          bit [31:0] v;
          if (m_count > 0 && $urandom_range(0, 4) != 0)
            w = (m_head + int'($urandom_range(0, m_count - 1))) % DEPTH;
          else
            w = int'($urandom_range(0, DEPTH - 1));
          v = $urandom;
          if (m[w].typ == 2'd2 && $urandom_range(0, 1) == 1) v = m[w].pred;
          wb(k, w, v);
        end
      end
      bus.st_ok  = 1'($urandom_range(0, 1));
      bus.q1_idx = 4'($urandom_range(0, DEPTH - 1));
      bus.q2_idx = 4'($urandom_range(0, DEPTH - 1));
      tick();
    end

    // reset asserted mid-run
    quiet();
    rdy_in = 1;
    rst_in = 0;
    model_reset();
    #1;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_flush", 32'(bus.flush_out), 32'd0);
    chk("midrst_q1",    32'(bus.q1_ready), 32'd0);
    chk("midrst_q2",    32'(bus.q2_ready), 32'd0);
    tick(); tick();
    rst_in = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
